rr_arbiter: RTL and testbench
=============================

RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, legal range 2..8.
REQ-002 Parameter MAX_HOLD, default 16: maximum grant length in cycles under contention, legal range 1..255.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset; sampled on the rising edge of clock.
REQ-005 req  input  NREQ  per-requester request level; bit i belongs to requester i.
REQ-006 gnt  output  NREQ  registered grant; one-hot or all-zero.
REQ-007 gnt_valid  output  1  registered; equals OR of gnt.
REQ-008 gnt_id  output  3  registered binary index of the granted requester; 0 when gnt_valid=0.

Function
REQ-009 State machine SHALL have three states: IDLE, GRANT and RELEASE. All outputs SHALL be registered.
REQ-010 Internal state SHALL include an owner index, a round-robin pointer ptr (0..NREQ-1) and a hold counter hold_cnt (0..MAX_HOLD, saturating).
REQ-011 Arbitration SHALL scan req starting at index ptr, then ptr+1, and so on, wrapping modulo NREQ. The first asserted bit wins.
REQ-012 IDLE, req=0: SHALL remain in IDLE with gnt=0.
REQ-013 IDLE, req!=0 at edge n: on edge n SHALL enter GRANT, set gnt=onehot(winner), gnt_id=winner, owner=winner and hold_cnt=1. Latency from req sampled to gnt visible is one edge.
REQ-014 GRANT with req[owner]=0 sampled: SHALL enter RELEASE, clear gnt, gnt_valid and gnt_id, and set ptr=(owner+1) mod NREQ.
REQ-015 GRANT with hold_cnt>=MAX_HOLD and (req & ~onehot(owner))!=0: SHALL preempt. Same actions as REQ-014.
REQ-016 GRANT otherwise: SHALL hold gnt unchanged and increment hold_cnt, saturating at MAX_HOLD. With a sole requester the grant SHALL persist indefinitely with no gap.
REQ-017 Under continuous contention, each grant SHALL be exactly MAX_HOLD cycles high, followed by exactly one cycle of gnt=0.
REQ-018 RELEASE: gnt SHALL be 0 for this cycle. Arbitration SHALL run per REQ-011 using the updated ptr. If req!=0, SHALL enter GRANT per REQ-013; otherwise SHALL enter IDLE.
REQ-019 A preempted owner still requesting SHALL rejoin rotation at lowest priority relative to the new ptr. It SHALL NOT be re-granted before every other pending requester has been served once.
REQ-020 Request changes on non-owner bits during GRANT SHALL NOT affect gnt. They SHALL only affect the preemption condition in REQ-015.
REQ-021 ptr SHALL change only on GRANT exit. With owner=NREQ-1, ptr SHALL wrap to 0.
REQ-022 gnt SHALL never have more than one bit set, including immediately after reset.
REQ-023 gnt_valid and gnt_id SHALL always be consistent with gnt in the same cycle.

Reset
REQ-024 When reset=1 at an edge: state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, ptr=0, owner=0, hold_cnt=0.
REQ-025 Reset SHALL take priority over all transitions, including a reset asserted mid-GRANT or during RELEASE. No grant SHALL be issued on the edge where reset=1.
REQ-026 Arbitration SHALL resume on the first edge with reset=0, with ptr=0.

Verification
REQ-027 Reset held with req=4'b1111, then released → gnt=0 throughout reset; gnt=4'b0001, gnt_id=0 after the first edge with reset=0.
REQ-028 NREQ=4, MAX_HOLD=4, req=4'b1111 held → gnt sequence: 0001 for 4 cycles, 0000 for 1, 0010 for 4, 0000 for 1, 0100 for 4, 0000 for 1, 1000 for 4, 0000 for 1, then 0001 again.
REQ-029 Only req[2]=1, held for 40 cycles → gnt=4'b0100 continuously for 40 cycles; hold_cnt saturates; no RELEASE gap.
REQ-030 req[1] granted, req[1] dropped after 2 grant cycles, req[3]=1 pending → gnt=0010 for 3 cycles (registered drop), then one 0000 cycle, then gnt=1000.
REQ-031 Wrap-around: req[3] served and released (ptr=0), then req=4'b1001 → gnt=4'b0001. After 0001 releases, gnt=4'b1000.
REQ-032 Reset asserted on the second cycle of a grant to req[2] with req=4'b0110 → gnt=0 on that edge; after release, the first grant goes to requester 1 (ptr=0).

Source files
------------

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with bounded grant length and a one-cycle release gap
// Grants, grant id and valid are all registered; ptr moves only when a grant ends.
module rr_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_valid,
  output logic [2:0]      gnt_id
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t          state, state_nxt;
  logic [2:0]      owner, owner_nxt;
  logic [2:0]      ptr, ptr_nxt;
  logic [7:0]      hold_cnt, hold_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic            gnt_valid_nxt;
  logic [2:0]      gnt_id_nxt;

  logic [NREQ-1:0] rot;
  logic [NREQ-1:0] owner_mask;
  logic            win_found;
  logic [2:0]      winner;
  logic            owner_req;
  logic            others_req;
  logic            expire;
  logic            leave;

  // Rotate req so that bit 0 is the requester at ptr; the first set bit wins.
  always_comb begin
    rot       = NREQ'({req, req} >> ptr);
    win_found = 1'b0;
    winner    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && |(rot & (NREQ'(1) << i))) begin
        win_found = 1'b1;
        winner    = 3'((int'(ptr) + i) % NREQ);
      end
    end
  end

  assign owner_mask = NREQ'(1) << owner;
  assign owner_req  = |(req & owner_mask);
  assign others_req = |(req & ~owner_mask);
  assign expire     = hold_cnt >= 8'(MAX_HOLD);
  assign leave      = !owner_req || (expire && others_req);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      owner     <= '0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= gnt_valid_nxt;
      gnt_id    <= gnt_id_nxt;
      owner     <= owner_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = win_found ? GRANT : IDLE;
      GRANT:   state_nxt = leave ? RELEASE : GRANT;
      RELEASE: state_nxt = win_found ? GRANT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_nxt       = gnt;
    gnt_valid_nxt = gnt_valid;
    gnt_id_nxt    = gnt_id;
    owner_nxt     = owner;
    ptr_nxt       = ptr;
    hold_nxt      = hold_cnt;
    case (state)
      GRANT: begin
        if (leave) begin
          gnt_nxt       = '0;
          gnt_valid_nxt = 1'b0;
          gnt_id_nxt    = '0;
          ptr_nxt       = (owner == 3'(NREQ - 1)) ? 3'd0 : owner + 3'd1;
        end else if (!expire) begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      default: begin
        if (win_found) begin
          gnt_nxt       = NREQ'(1) << winner;
          gnt_valid_nxt = 1'b1;
          gnt_id_nxt    = winner;
          owner_nxt     = winner;
          hold_nxt      = 8'd1;
        end else begin
          gnt_nxt       = '0;
          gnt_valid_nxt = 1'b0;
          gnt_id_nxt    = '0;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - directed bench for rr_arbiter with NREQ=4, MAX_HOLD=4
// A per-cycle vector table covers reset and full contention; short sequences cover the corner cases.
module tb_rr_arbiter;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_id;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [2:0] id;
  } vec_t;

  vec_t vecs[$];

  rr_arbiter #(.NREQ(4), .MAX_HOLD(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void add(input logic rst, input logic [3:0] r, input logic [3:0] eg, input logic [2:0] eid);
    vec_t v;
    v.rst = rst;
    v.req = r;
    v.gnt = eg;
    v.id  = eid;
    vecs.push_back(v);
  endfunction

  // Inputs are sampled on the next edge; expected values are the outputs after that edge.
  task automatic step(input logic rst, input logic [3:0] r, input logic [3:0] eg, input logic [2:0] eid, input string tag);
    reset = rst;
    req   = r;
    @(posedge clock);
    #1;
    checks++;
    if (gnt !== eg || gnt_valid !== (|eg) || gnt_id !== eid) begin
      errors++;
      $display("FAIL %s: gnt=%b valid=%b id=%0d, expected gnt=%b valid=%b id=%0d",
               tag, gnt, gnt_valid, gnt_id, eg, |eg, eid);
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;

    for (int i = 0; i < 3; i++) add(1'b1, 4'b1111, 4'b0000, 3'd0);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) add(1'b0, 4'b1111, 4'(1 << k), 3'(k));
      add(1'b0, 4'b1111, 4'b0000, 3'd0);
    end
    add(1'b0, 4'b1111, 4'b0001, 3'd0);
    add(1'b0, 4'b0000, 4'b0000, 3'd0);
    add(1'b0, 4'b0000, 4'b0000, 3'd0);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].rst, vecs[i].req, vecs[i].gnt, vecs[i].id, $sformatf("vec%0d", i));

    // Sole requester keeps the grant with no release gap.
    step(1'b1, 4'b0000, 4'b0000, 3'd0, "solo_reset");
    for (int i = 0; i < 40; i++) step(1'b0, 4'b0100, 4'b0100, 3'd2, $sformatf("solo%0d", i));
    step(1'b0, 4'b0000, 4'b0000, 3'd0, "solo_release");
    step(1'b0, 4'b0000, 4'b0000, 3'd0, "solo_idle");

    // Owner drops its request while another waits.
    step(1'b1, 4'b0000, 4'b0000, 3'd0, "drop_reset");
    step(1'b0, 4'b1010, 4'b0010, 3'd1, "drop_g1");
    step(1'b0, 4'b1010, 4'b0010, 3'd1, "drop_g2");
    step(1'b0, 4'b1010, 4'b0010, 3'd1, "drop_g3");
    step(1'b0, 4'b1000, 4'b0000, 3'd0, "drop_gap");
    step(1'b0, 4'b1000, 4'b1000, 3'd3, "drop_next");
    step(1'b0, 4'b0000, 4'b0000, 3'd0, "drop_release");

    // Pointer wraps from requester 3 back to 0.
    step(1'b1, 4'b0000, 4'b0000, 3'd0, "wrap_reset");
    step(1'b0, 4'b1000, 4'b1000, 3'd3, "wrap_g3");
    step(1'b0, 4'b0000, 4'b0000, 3'd0, "wrap_release");
    step(1'b0, 4'b0000, 4'b0000, 3'd0, "wrap_idle");
    step(1'b0, 4'b1001, 4'b0001, 3'd0, "wrap_g0");
    step(1'b0, 4'b1000, 4'b0000, 3'd0, "wrap_gap");
    step(1'b0, 4'b1000, 4'b1000, 3'd3, "wrap_g3b");

    // Reset mid-grant clears the grant and restarts from ptr=0.
    step(1'b1, 4'b0000, 4'b0000, 3'd0, "mid_reset0");
    step(1'b0, 4'b0100, 4'b0100, 3'd2, "mid_g2a");
    step(1'b0, 4'b0110, 4'b0100, 3'd2, "mid_g2b");
    step(1'b1, 4'b0110, 4'b0000, 3'd0, "mid_reset");
    step(1'b0, 4'b0110, 4'b0010, 3'd1, "mid_g1");

    // Reset during the release gap.
    step(1'b0, 4'b0000, 4'b0000, 3'd0, "rel_release");
    step(1'b1, 4'b1000, 4'b0000, 3'd0, "rel_reset");
    step(1'b0, 4'b1100, 4'b0100, 3'd2, "rel_g2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
